operand_fetch: RTL and testbench

Operand-fetch stage sitting directly downstream of the 32×32 register file. It accepts one decoded instruction word at a time and sequences the register file's single synchronous read port to fetch the `rs` and `rt` operands. It snoops the register file's write port so the operands it presents are never stale. It then presents the instruction plus both operands to the execute stage over a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/operand_slot.sv | 60 ++++++
 rtl/operand_fetch.sv | 111 +++++++++++
 tb/tb_operand_fetch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the operand-fetch FSM state encoding.
package cpu_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 32;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_RS = 2'd1,
    S_RD_RT = 2'd2,
    S_DONE  = 2'd3
  } of_state_t;
endpackage

// File: rtl/operand_slot.sv
// One register operand: forwards writes seen while its read is in flight and
// keeps the held value coherent with write-back until execute takes it.
module operand_slot #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              present,
  input  logic              capture,
  input  logic              hold,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] value
);
  logic              match;
  logic              fwd_flag;
  logic [DATA_W-1:0] fwd_val;
  logic [DATA_W-1:0] value_q;
  logic [DATA_W-1:0] cap_val;

  assign match = wb_we && (wb_addr == addr) && (addr != '0);

  // Newest source wins: same-cycle write, then write seen at presentation, then RF.
  always_comb begin
    cap_val = rd_data;
    if (addr == '0)    cap_val = '0;
    else if (match)    cap_val = wb_data;
    else if (fwd_flag) cap_val = fwd_val;
  end

  // Same-cycle bypass keeps rs and rt slots equal when they name one register.
  always_comb begin
    value = value_q;
    if (capture)            value = cap_val;
    else if (hold && match) value = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      fwd_flag <= 1'b0;
      fwd_val  <= '0;
    end else begin
      if (present) begin
        fwd_flag <= match;
        fwd_val  <= wb_data;
      end else if (capture) begin
        fwd_flag <= 1'b0;
      end
      if (clear) fwd_flag <= 1'b0;
      if (capture)            value_q <= cap_val;
      else if (hold && match) value_q <= wb_data;
    end
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: sequences the single RF read port for rs then rt and
// hands instruction plus coherent operands to execute over valid/ready.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  input  logic              wb_write_enable,
  input  logic [ADDR_W-1:0] wb_write_addr,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data
);
  import cpu_pkg::*;

  localparam int NUM_SLOTS = 2;

  of_state_t          state, state_n;
  logic [INSTR_W-1:0] instr_q;
  logic               out_valid_q;
  logic               done_first;
  logic               accept;

  logic [NUM_SLOTS-1:0][ADDR_W-1:0] slot_addr;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] slot_val;
  logic [NUM_SLOTS-1:0]             slot_present, slot_capture, slot_hold;

  assign in_ready = ((state == S_IDLE) || ((state == S_DONE) && out_ready)) && !flush && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n = state;
    if (flush) state_n = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (accept) state_n = S_RD_RS;
        S_RD_RS: state_n = S_RD_RT;
        S_RD_RT: state_n = S_DONE;
        S_DONE:  if (out_ready) state_n = accept ? S_RD_RS : S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      out_valid_q <= 1'b0;
      done_first  <= 1'b0;
    end else begin
      state       <= state_n;
      out_valid_q <= (state_n == S_DONE);
      done_first  <= (state == S_RD_RT) && !flush;
      if (accept) instr_q <= in_instr;
    end
  end

  // Read address depends only on registered state and the latched instruction.
  always_comb begin
    rf_read_addr = '0;
    case (state)
      S_RD_RS: rf_read_addr = slot_addr[0];
      S_RD_RT: rf_read_addr = slot_addr[1];
      default: rf_read_addr = '0;
    endcase
  end

  assign slot_addr[0] = instr_q[RS_LSB +: ADDR_W];
  assign slot_addr[1] = instr_q[RT_LSB +: ADDR_W];

  // rs: present in RD_RS, capture in RD_RT; rt: present in RD_RT, capture on DONE entry.
  assign slot_present[0] = (state == S_RD_RS) && !flush;
  assign slot_capture[0] = (state == S_RD_RT) && !flush;
  assign slot_hold[0]    = (state == S_DONE)  && !flush;
  assign slot_present[1] = (state == S_RD_RT) && !flush;
  assign slot_capture[1] = (state == S_DONE)  && done_first && !flush;
  assign slot_hold[1]    = (state == S_DONE)  && !done_first && !flush;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : gen_slot
    operand_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .present (slot_present[g]),
      .capture (slot_capture[g]),
      .hold    (slot_hold[g]),
      .addr    (slot_addr[g]),
      .rd_data (rf_read_data),
      .wb_we   (wb_write_enable),
      .wb_addr (wb_write_addr),
      .wb_data (wb_write_data),
      .value   (slot_val[g])
    );
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = instr_q;
  assign out_rs_data = slot_val[0];
  assign out_rt_data = slot_val[1];
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboarded bench for operand_fetch with a behavioural synchronous-read RF.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_instr, rf_read_data, wb_write_data, out_rs_data, out_rt_data;
  logic [4:0]  rf_read_addr, wb_write_addr;
  logic        wb_write_enable;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [31:0] instr, rs, rt; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] rf [32];

  operand_fetch dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Register file: read returns pre-write contents; r0 reads garbage to prove forcing.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      rf_read_data <= '0;
    end else begin
      rf_read_data <= (rf_read_addr == 5'd0) ? 32'hDEAD_BEEF : rf[rf_read_addr];
      if (wb_write_enable && wb_write_addr != 5'd0) rf[wb_write_addr] <= wb_write_data;
    end
  end

  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL handshake_unexpected instr=%h rs=%h rt=%h", out_instr, out_rs_data, out_rt_data);
      end else begin
        mon_e = sb.pop_front();
        if (out_instr !== mon_e.instr || out_rs_data !== mon_e.rs || out_rt_data !== mon_e.rt) begin
          errors++;
          $display("FAIL handshake got instr=%h rs=%h rt=%h exp instr=%h rs=%h rt=%h",
                   out_instr, out_rs_data, out_rt_data, mon_e.instr, mon_e.rs, mon_e.rt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got cycle=%0d exp finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    wb_write_enable = 1'b1; wb_write_addr = a; wb_write_data = d;
    step();
    wb_write_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    wb_write_enable = 1'b0; wb_write_addr = '0; wb_write_data = '0;
    step(); step();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    step(); rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
    checks++; if ({out_instr, out_rs_data, out_rt_data} !== 96'd0 || rf_read_addr !== 5'd0)
      begin errors++; $display("FAIL reset_outputs got %h %h %h a=%0d exp zeros", out_instr, out_rs_data, out_rt_data, rf_read_addr); end
  endtask

  task automatic test_basic();
    step(); out_ready = 1'b1;
    poke(5'd3, 32'h11); poke(5'd4, 32'h22);
    in_valid = 1'b1; in_instr = mk(5'd3, 5'd4, 16'h0001);
    sb.push_back('{mk(5'd3, 5'd4, 16'h0001), 32'h11, 32'h22});
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_accept got %b exp 1", in_ready); end
    step(); in_valid = 1'b0;
    @(negedge clk);
    checks++; if (rf_read_addr !== 5'd3) begin errors++; $display("FAIL basic_rs_addr got %0d exp 3", rf_read_addr); end
    step();
    @(negedge clk);
    checks++; if (rf_read_addr !== 5'd4 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_rt_addr got %0d v=%b exp 4 v=0", rf_read_addr, out_valid); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_t3 got v=%b r=%b exp 1 1", out_valid, in_ready); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_fwd_present();
    step(); out_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(5'd3, 5'd4, 16'h0002);
    sb.push_back('{mk(5'd3, 5'd4, 16'h0002), 32'hAA, 32'h22});
    step(); in_valid = 1'b0;
    wb_write_enable = 1'b1; wb_write_addr = 5'd3; wb_write_data = 32'hAA;
    step(); wb_write_enable = 1'b0;
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rs_data !== 32'hAA) begin errors++; $display("FAIL fwd_present got v=%b rs=%h exp 1 aa", out_valid, out_rs_data); end
  endtask

  task automatic test_hold_update();
    step(); out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk(5'd3, 5'd4, 16'h0003);
    sb.push_back('{mk(5'd3, 5'd4, 16'h0003), 32'hAA, 32'hCC});
    step(); in_valid = 1'b0;
    step();
    step(); wb_write_enable = 1'b1; wb_write_addr = 5'd4; wb_write_data = 32'hBB;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rt_data !== 32'hBB) begin errors++; $display("FAIL hold_capture got v=%b rt=%h exp 1 bb", out_valid, out_rt_data); end
    step(); wb_write_enable = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rt_data !== 32'hBB) begin errors++; $display("FAIL hold_keep got v=%b rt=%h exp 1 bb", out_valid, out_rt_data); end
    step(); wb_write_enable = 1'b1; wb_write_data = 32'hCC;
    step(); wb_write_enable = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_rt_data !== 32'hCC) begin errors++; $display("FAIL hold_update got %h exp cc", out_rt_data); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", out_valid); end
  endtask

  task automatic test_same_reg();
    step(); out_ready = 1'b1;
    poke(5'd5, 32'h77);
    in_valid = 1'b1; in_instr = mk(5'd5, 5'd5, 16'h0004);
    sb.push_back('{mk(5'd5, 5'd5, 16'h0004), 32'h99, 32'h99});
    step(); in_valid = 1'b0;
    step(); wb_write_enable = 1'b1; wb_write_addr = 5'd5; wb_write_data = 32'h99;
    step(); wb_write_enable = 1'b0;
    @(negedge clk);
    checks++; if (out_rs_data !== out_rt_data || out_rt_data !== 32'h99) begin errors++; $display("FAIL same_reg got rs=%h rt=%h exp 99 99", out_rs_data, out_rt_data); end
  endtask

  task automatic test_zero();
    step(); out_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(5'd0, 5'd0, 16'h0005);
    sb.push_back('{mk(5'd0, 5'd0, 16'h0005), 32'h0, 32'h0});
    step(); in_valid = 1'b0;
    wb_write_enable = 1'b1; wb_write_addr = 5'd0; wb_write_data = 32'h55;
    step(); step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rs_data !== 32'h0 || out_rt_data !== 32'h0)
      begin errors++; $display("FAIL zero_reg got v=%b rs=%h rt=%h exp 1 0 0", out_valid, out_rs_data, out_rt_data); end
    step(); wb_write_enable = 1'b0;
  endtask

  task automatic test_flush();
    step(); out_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(5'd3, 5'd4, 16'h0006);
    step(); in_valid = 1'b0;
    step(); flush = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    step(); flush = 1'b0;
    in_valid = 1'b1; in_instr = mk(5'd4, 5'd3, 16'h0007);
    sb.push_back('{mk(5'd4, 5'd3, 16'h0007), 32'hCC, 32'hAA});
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || rf_read_addr !== 5'd0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_idle got v=%b a=%0d r=%b exp 0 0 1", out_valid, rf_read_addr, in_ready); end
    step(); in_valid = 1'b0;
    step(); step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got %b exp 1", out_valid); end
    // flush against a ready handshake in DONE
    step(); out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk(5'd3, 5'd3, 16'h0008);
    step(); in_valid = 1'b0;
    step(); step(); step();
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_vs_ready got %b exp 0", in_ready); end
    step(); flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_beats_handshake got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int acc[3];
    bit got;
    step(); out_ready = 1'b1;
    for (int r = 6; r <= 8; r++) poke(5'(r), 32'(r * 32'h101));
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_instr = mk(5'(6 + k), 5'(8 - k), 16'(k));
      got = 1'b0;
      acc[k] = 0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        if (in_ready) begin
          got = 1'b1; acc[k] = cyc;
          sb.push_back('{mk(5'(6 + k), 5'(8 - k), 16'(k)), 32'((6 + k) * 32'h101), 32'((8 - k) * 32'h101)});
        end
        @(posedge clk); #1;
      end
      checks++; if (!got) begin errors++; $display("FAIL b2b_accept_timeout got none exp accept k=%0d", k); end
    end
    in_valid = 1'b0;
    checks++; if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3)
      begin errors++; $display("FAIL b2b_spacing got %0d %0d exp 3 3", acc[1] - acc[0], acc[2] - acc[1]); end
    step(); step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_last_valid got %b exp 1", out_valid); end
  endtask

  task automatic test_reset_mid();
    step(); out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk(5'd3, 5'd4, 16'h0009);
    step(); in_valid = 1'b0;
    step(); step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b exp 1", out_valid); end
    step(); rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b exp 0", in_ready); end
    step(); rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || {out_instr, out_rs_data, out_rt_data} !== 96'd0 || rf_read_addr !== 5'd0)
      begin errors++; $display("FAIL rstmid_outputs got v=%b %h %h %h exp 0 zeros", out_valid, out_instr, out_rs_data, out_rt_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after got %b exp 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fwd_present();
    test_hold_update();
    test_same_reg();
    test_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    step();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
